// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data,
// optional even parity, stop bit; every bit held for DIV clock cycles.
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             par, par_n;
    logic             sout_n, ready_n, busy_n, done_n;

    // Outputs are computed from the next-state values and then registered,
    // so they change on the same edge as the state they decode.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        if (state == IDLE) begin
            timer_n  = '0;
            bitcnt_n = '0;
            if (load) begin
                state_n = START;
                shreg_n = din;
                par_n   = ^din;
            end
        end else if (timer != TLAST) begin
            timer_n = timer + TW'(1);
        end else begin
            timer_n = '0;
            case (state)
                START: begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
                DATA: begin
                    shreg_n  = shreg >> 1;
                    bitcnt_n = bitcnt + BW'(1);
                    if (bitcnt == BLAST)
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY:  state_n = STOP;
                STOP:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        sout_n = 1'b1;
        case (state_n)
            START:   sout_n = 1'b0;
            DATA:    sout_n = shreg_n[0];
            PARITY:  sout_n = par_n;
            default: sout_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == STOP) && (timer_n == TLAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            sout   <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            par    <= par_n;
            sout   <= sout_n;
            ready  <= ready_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three builds (8/4/parity, 8/4/no parity, 5/1/parity)
// checked every cycle against a queue-of-line-levels frame model.
module tb_serial_frame_tx;

    localparam int WA [0:2] = '{8, 8, 5};
    localparam int DA [0:2] = '{4, 4, 1};
    localparam int PA [0:2] = '{1, 0, 1};

    typedef bit bitq_t[$];

    typedef struct {
        bit         rst;
        bit         load;
        logic [7:0] din;
        bit         sout;
        bit         ready;
        bit         busy;
        bit         done;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [2:0] load_a;
    logic [2:0] ready_a, sout_a, busy_a, done_a;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    done_first [3];
    int    done_last  [3];
    bitq_t mq [3];
    vec_t  tbl [12];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_frame_tx #(
            .WIDTH    (WA[g]),
            .DIV      (DA[g]),
            .PARITY_EN(PA[g])
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .din  (din[WA[g]-1:0]),
            .load (load_a[g]),
            .ready(ready_a[g]),
            .sout (sout_a[g]),
            .busy (busy_a[g]),
            .done (done_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line levels of a whole frame, one entry per clock cycle.
    function automatic bitq_t frame(input logic [7:0] d, input int w, input int dv, input int pe);
        bitq_t f;
        bit    b[$];
        int    ones = 0;
        b.push_back(1'b0);
        for (int k = 0; k < w; k++) begin
            b.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (pe != 0) b.push_back(bit'(ones % 2));
        b.push_back(1'b1);
        foreach (b[i]) repeat (dv) f.push_back(b[i]);
        return f;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_done();
        for (int g = 0; g < 3; g++) begin
            done_first[g] = -1;
            done_last[g]  = -1;
        end
    endtask

    task automatic tick();
        bit    acc;
        bit    es;
        bitq_t f;
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                mq[g].delete();
            end else begin
                acc = load_a[g] && (mq[g].size() == 0);
                if (mq[g].size() > 0) void'(mq[g].pop_front());
                if (acc) begin
                    f = frame(din, WA[g], DA[g], PA[g]);
                    foreach (f[i]) mq[g].push_back(f[i]);
                end
            end
        end
        @(negedge clk);
        cyc++;
        for (int g = 0; g < 3; g++) begin
            es = (mq[g].size() == 0) ? 1'b1 : mq[g][0];
            chk($sformatf("u%0d.sout", g), int'(sout_a[g]), int'(es));
            chk($sformatf("u%0d.ready", g), int'(ready_a[g]), int'(mq[g].size() == 0));
            chk($sformatf("u%0d.busy", g), int'(busy_a[g]), int'(mq[g].size() != 0));
            chk($sformatf("u%0d.done", g), int'(done_a[g]), int'(mq[g].size() == 1));
            if (done_a[g]) begin
                if (done_first[g] < 0) done_first[g] = cyc;
                done_last[g] = cyc;
            end
        end
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        rst    = 1'b0;
        load_a = '0;
        while (ready_a != 3'b111 && n < 200) begin
            tick();
            n++;
        end
        chk("wait_idle", int'(ready_a), 7);
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (done_first[g] < 0 && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d.done_seen", g), int'(done_first[g] >= 0), 1);
    endtask

    initial begin
        int e;
        //                rst load din    sout rdy busy done
        tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        clear_done();
        e = 0;
        for (int i = 0; i < 12; i++) begin
            rst    = tbl[i].rst;
            load_a = {3{tbl[i].load}};
            din    = tbl[i].din;
            if (i == 3) clear_done();
            tick();
            if (i == 3) e = cyc - 1;
            chk("tbl.sout", int'(sout_a[0]), int'(tbl[i].sout));
            chk("tbl.ready", int'(ready_a[0]), int'(tbl[i].ready));
            chk("tbl.busy", int'(busy_a[0]), int'(tbl[i].busy));
            chk("tbl.done", int'(done_a[0]), int'(tbl[i].done));
        end

        // Load pulse while busy must not disturb the 0xA5 frame.
        tick();
        load_a = 3'b111;
        din    = 8'h3C;
        tick();
        load_a = '0;
        wait_done(0);
        chk("a5.done_u0", done_first[0], e + 44);
        chk("a5.done_u1", done_first[1], e + 40);
        chk("a5.done_u2", done_first[2], e + 8);
        tick();
        chk("a5.ready_after", int'(ready_a[0]), 1);

        // 0x07 has odd weight, so the even-parity bit is 1.
        wait_idle();
        clear_done();
        load_a = 3'b011;
        din    = 8'h07;
        e      = cyc;
        tick();
        load_a = '0;
        run_until(e + 37);
        chk("p07.parity_bit", int'(sout_a[0]), 1);
        wait_done(0);
        chk("p07.done_u0", done_first[0], e + 44);
        chk("p07.done_u1", done_first[1], e + 40);

        // Back-to-back frames with load held high.
        wait_idle();
        clear_done();
        load_a = 3'b111;
        din    = 8'h00;
        e      = cyc;
        run_until(e + 45);
        chk("b2b.gap_sout", int'(sout_a[0]), 1);
        chk("b2b.gap_ready", int'(ready_a[0]), 1);
        din = 8'hFF;
        tick();
        chk("b2b.start2", int'(sout_a[0]), 0);
        run_until(e + 89);
        load_a = '0;
        chk("b2b.done1", done_first[0], e + 44);
        chk("b2b.done2", done_last[0], e + 89);

        // Abort mid-frame, then a clean frame.
        wait_idle();
        load_a = 3'b111;
        din    = 8'h5B;
        e      = cyc;
        tick();
        load_a = '0;
        run_until(e + 19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.sout", int'(sout_a[0]), 1);
        chk("abort.busy", int'(busy_a[0]), 0);
        chk("abort.ready", int'(ready_a[0]), 1);
        clear_done();
        repeat (30) tick();
        chk("abort.no_done", done_first[0], -1);
        load_a = 3'b111;
        din    = 8'hC6;
        e      = cyc;
        tick();
        load_a = '0;
        wait_done(0);
        chk("abort.refill_done", done_first[0], e + 44);

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst    = ($urandom_range(0, 99) == 0);
            load_a = 3'($urandom);
            din    = 8'($urandom);
            tick();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
